dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MIPS-Lite pipeline: the memory-side end of the MEM-stage load/store interface. It accepts one load or store request at a time over a valid/ready handshake and holds the word-addressed data array. Loads complete after a configurable latency; stores complete after one cycle. It drives a stall back to the pipeline until each response is delivered.

## Interface
Parameters
- DEPTH, 1024: number of 32-bit words; power of two.
- READ_LATENCY, 2: cycles from load acceptance to response; must be at least 1.

Ports
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  MEM stage presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDRESSWIDTH  byte address.
- req_wdata  in  DATA  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA  load data. 0 for stores and errors.
- resp_err  out  1  misaligned access (see Configuration).
- stall  out  1  pipeline must hold the MEM stage.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid:
    - Capture the address, write flag and data.
    - Store: write the array at this edge, then go to RESP.
    - Load with READ_LATENCY = 1: go to RESP.
    - Load with READ_LATENCY > 1: go to BUSY with cnt = READ_LATENCY-1.
- BUSY
  - req_ready = 0.
  - cnt decrements each cycle.
  - When cnt == 1, go to RESP.
- RESP
  - req_ready = 0, resp_valid = 1 for exactly one cycle.
  - Always return to IDLE next.
  - A new request can be accepted in the cycle after RESP at the earliest.
- Load data is read from the array on the edge entering RESP and registered into resp_rdata.
- Word index = req_addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- stall = (state == BUSY) | (state == IDLE & req_valid).
  - Deasserted in RESP and in IDLE with no request.
- A store followed by a load to the same word returns the new data.
- Request inputs are ignored outside IDLE.

## Timing
- Reset:
  - State IDLE, cnt 0, resp_valid 0, resp_rdata 0, resp_err 0.
  - req_ready is 1 in the cycle after reset deasserts.
  - All array words are cleared to 0.
- Reset during BUSY or RESP drops the pending request. No response is issued. A store that was already committed stays committed unless the array clear overwrites it.
- Store accepted in cycle 0: resp_valid in cycle 1.
- Load accepted in cycle 0: resp_valid in cycle READ_LATENCY.
- stall is high from the acceptance cycle through the cycle before RESP.
- resp_rdata and resp_err are valid only while resp_valid = 1. Both hold 0 otherwise.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - Any request with req_addr[1:0] != 0 is accepted and goes straight to RESP (response in cycle 1).
  - resp_err = 1 and resp_rdata = 0.
  - Misaligned stores do not modify the array.
- DMEM_ALIGN_CHECK_EN undefined:
  - req_addr[1:0] is ignored.
  - resp_err is tied to 0.

## Structure
- mips_pkg additions:
  - dmem_state_t enum (IDLE, BUSY, RESP).
  - DMEM_DEPTH default constant.
  - Reuses existing DATA and ADDRESSWIDTH.
- One sub-module, dmem_array:
  - DEPTH x DATA storage.
  - Synchronous write enable and synchronous clear on reset.
  - Combinational read port.
- The FSM, counter and handshake live in dmem_responder.

## Test plan
- Reset, then idle: req_ready = 1, resp_valid = 0, stall = 0. Load from 0x40 (READ_LATENCY = 2) returns resp_rdata = 0 in cycle 2.
- Store 0xDEADBEEF to 0x10: resp_valid in cycle 1, stall high in cycle 0 only. Then load 0x10: resp_rdata = 0xDEADBEEF in cycle 2.
- Back-to-back requests with req_valid held high: each is accepted only in IDLE. req_ready = 0 during BUSY and RESP. Exactly one resp_valid pulse per request.
- Wrap-around with DEPTH = 1024: store 0x11 to 0x1000, then load 0x0 returns 0x11.
- Reset asserted in BUSY: resp_valid never pulses for that load. IDLE with req_ready = 1 the cycle after reset deasserts.
- DMEM_ALIGN_CHECK_EN defined: store 0x55 to 0x22 gives resp_err = 1 in cycle 1. A subsequent load of 0x20 returns the prior contents (0 after reset).

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS-Lite types and constants.
//   DATA          - datapath word width
//   ADDRESSWIDTH  - byte address width
//   DMEM_DEPTH    - default data-memory depth in words
//   dmem_state_t  - data-memory responder FSM states
package mips_pkg;

  localparam int unsigned DATA         = 32;
  localparam int unsigned ADDRESSWIDTH = 32;
  localparam int unsigned DMEM_DEPTH   = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store bus between pipeline and data memory.
//   master (pipeline): drives req_valid/req_write/req_addr/req_wdata,
//                      observes req_ready/resp_valid/resp_rdata/resp_err/stall
//   slave  (memory)  : the reverse
interface dmem_responder_if
  import mips_pkg::*;
();

  logic                    req_valid;
  logic                    req_write;
  logic [ADDRESSWIDTH-1:0] req_addr;
  logic [DATA-1:0]         req_wdata;
  logic                    req_ready;
  logic                    resp_valid;
  logic [DATA-1:0]         resp_rdata;
  logic                    resp_err;
  logic                    stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA word storage for the data memory.
//   clk, reset : clock; synchronous active-high clear of every word
//   i_we       : write enable (synchronous)
//   i_waddr    : write word index
//   i_wdata    : write data
//   i_raddr    : read word index (combinational read)
//   o_rdata    : read data
module dmem_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [IW-1:0]   i_waddr,
  input  logic [DATA-1:0] i_wdata,
  input  logic [IW-1:0]   i_raddr,
  output logic [DATA-1:0] o_rdata
);

  logic [DATA-1:0] r_mem [DEPTH];

  // Storage with whole-array clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[IW'(i)] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the MEM-stage load/store interface.
// Accepts one request at a time; stores respond one cycle after acceptance,
// loads READ_LATENCY cycles after acceptance. Stall is held toward the
// pipeline from acceptance until the cycle before the response.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_responder_if.slave (request/response/stall)
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses
// with resp_err (misaligned stores leave the array untouched).
module dmem_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH        = DMEM_DEPTH,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  dmem_state_t     r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [IW-1:0]   w_req_idx, w_rd_idx;
  logic            r_resp_valid, w_resp_valid_nxt;
  logic [DATA-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic            r_resp_err, w_resp_err_nxt;
  logic            w_we, w_misalign, w_req_ready, w_stall;
  logic [DATA-1:0] w_arr_rdata;
  logic            w_unused_addr;

  // Word index; upper address bits are dropped so accesses wrap modulo DEPTH.
  assign w_req_idx     = bus.req_addr[IW+1:2];
  assign w_unused_addr = ^{bus.req_addr[ADDRESSWIDTH-1:IW+2], bus.req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = |bus.req_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  // State and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  // Next state, handshake and response values.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_we             = 1'b0;
    w_rd_idx         = r_idx;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = '0;
    w_resp_err_nxt   = 1'b0;
    w_req_ready      = 1'b0;
    w_stall          = 1'b0;

    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        w_stall     = bus.req_valid;
        w_rd_idx    = w_req_idx;
        if (bus.req_valid) begin
          w_idx_nxt = w_req_idx;
          if (w_misalign) begin
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else if (bus.req_write) begin
            w_we             = 1'b1;
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
          end else if (READ_LATENCY <= 1) begin
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_rdata_nxt = w_arr_rdata;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CW'(READ_LATENCY - 1);
          end
        end
      end

      BUSY: begin
        w_stall = 1'b1;
        // Load data is sampled on the edge that enters RESP.
        if (r_cnt == CW'(1)) begin
          w_state_nxt      = RESP;
          w_cnt_nxt        = '0;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = w_arr_rdata;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_req_idx),
    .i_wdata (bus.req_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_arr_rdata)
  );

  assign bus.req_ready  = w_req_ready;
  assign bus.stall      = w_stall;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder (DEPTH=1024,
// READ_LATENCY=2). Vector table plus hand sequences for back-to-back and
// reset-during-BUSY; response data checked through a scoreboard queue.
module tb_dmem_responder;
  import mips_pkg::*;

  localparam int unsigned RL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(1024), .READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int lat);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
    return v;
  endfunction

  // Scoreboard monitor: every response pops one expectation; idle cycles hold zeros.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", 32'(bus.resp_err), 32'(e.err));
        end
      end else begin
        check("idle_rdata", bus.resp_rdata, 32'd0);
        check("idle_err", 32'(bus.resp_err), 32'd0);
      end
    end
  end

  // Issue one request and check handshake/stall timing up to its response.
  task automatic send(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_q.push_back(e);
    #1;
    check({v.name, "_ready_c0"}, 32'(bus.req_ready), 32'd1);
    check({v.name, "_stall_c0"}, 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      check({v.name, "_valid"}, 32'(bus.resp_valid), 32'(k == v.lat));
      check({v.name, "_stall"}, 32'(bus.stall), 32'(k < v.lat));
      check({v.name, "_ready"}, 32'(bus.req_ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[13];
    exp_t e;
    vecs[0]  = mk("ld40",   1'b0, 32'h40,   32'h0,        32'h0,        1'b0, RL);
    vecs[1]  = mk("st10",   1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1);
    vecs[2]  = mk("ld10",   1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, RL);
    vecs[3]  = mk("st1000", 1'b1, 32'h1000, 32'h11,       32'h0,        1'b0, 1);
    vecs[4]  = mk("ld0",    1'b0, 32'h0,    32'h0,        32'h11,       1'b0, RL);
    vecs[5]  = mk("stffc",  1'b1, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0, 1);
    vecs[6]  = mk("ldffc",  1'b0, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0, RL);
    vecs[7]  = mk("ld1ffc", 1'b0, 32'h1FFC, 32'h0,        32'hCAFEF00D, 1'b0, RL);
    vecs[8]  = mk("st10b",  1'b1, 32'h10,   32'h12345678, 32'h0,        1'b0, 1);
    vecs[9]  = mk("ld4010", 1'b0, 32'h4010, 32'h0,        32'h12345678, 1'b0, RL);
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[10] = mk("st22",   1'b1, 32'h22,   32'h55,       32'h0,        1'b1, 1);
    vecs[11] = mk("ld20",   1'b0, 32'h20,   32'h0,        32'h0,        1'b0, RL);
    vecs[12] = mk("ld13",   1'b0, 32'h13,   32'h0,        32'h0,        1'b1, 1);
`else
    vecs[10] = mk("st22",   1'b1, 32'h22,   32'h55,       32'h0,        1'b0, 1);
    vecs[11] = mk("ld20",   1'b0, 32'h20,   32'h0,        32'h55,       1'b0, RL);
    vecs[12] = mk("ld13",   1'b0, 32'h13,   32'h0,        32'h12345678, 1'b0, RL);
`endif

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset and idle state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);

    for (int i = 0; i < 13; i++) begin
      send(vecs[i]);
    end

    // Back-to-back loads with req_valid held: one accept per IDLE, 3-cycle cadence.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h10;
    e.rdata = 32'h12345678;
    e.err   = 1'b0;
    sb_q.push_back(e);
    sb_q.push_back(e);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check("b2b_ready", 32'(bus.req_ready), 32'((k % 3) == 0));
      check("b2b_valid", 32'(bus.resp_valid), 32'((k % 3) == 2));
      check("b2b_stall", 32'(bus.stall), 32'((k % 3) != 2));
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("b2b_after_valid", 32'(bus.resp_valid), 32'd0);
      check("b2b_after_ready", 32'(bus.req_ready), 32'd1);
    end

    // Reset while a load is in BUSY: no response, array cleared.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    @(negedge clk);
    check("busy_stall", 32'(bus.stall), 32'd1);
    check("busy_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2_ready", 32'(bus.req_ready), 32'd1);
    check("rst2_stall", 32'(bus.stall), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst2_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    send(mk("ld10_clr",   1'b0, 32'h10,   32'h0, 32'h0, 1'b0, RL));
    send(mk("ld1000_clr", 1'b0, 32'h1000, 32'h0, 32'h0, 1'b0, RL));

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
